trap_ctrl: RTL

Synchronous, parametrised trap/NMI controller for the MegaMapper virtualization layer. Sits between the I/O decoder, the Z80 M1/interrupt lines and the mapper address-capture logic. It decides when the guest is preempted into the trap handler via NMI, records why, and releases the guest on the handler's untrap jump. It generalises the M1-edge-clocked controller to NUM_IRQ maskable interrupt sources, a latched trap cause and a nested-violation flag, all in one clock domain.

---
 rtl/trap_pkg.sv | 13 +
 rtl/trap_ctrl_if.sv | 33 +++
 rtl/sync_edge.sv | 32 +++
 rtl/trap_ctrl.sv | 122 ++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// Shared types for the MegaMapper trap/NMI controller.
package trap_pkg;

    typedef enum logic {
        GUEST   = 1'b0,
        TRAPPED = 1'b1
    } state_e;

    localparam int CAUSE_NONE     = 0;
    localparam int CAUSE_IOV      = 1;
    localparam int CAUSE_IRQ_BASE = 2;

endpackage

// File: rtl/trap_ctrl_if.sv
// Signal bundle between the I/O decoder, Z80 lines and the trap controller.
interface trap_ctrl_if #(
    parameter int NUM_IRQ = 4,
    parameter int CAUSE_W = 4
);
    logic               m1_n;
    logic [NUM_IRQ-1:0] irq_n;
    logic [NUM_IRQ-1:0] irq_mask;
    logic               io_violation;
    logic               new_isr;
    logic               last_isr_untrap;
    logic               virtual_enabled;
    logic               fault_clr;
    logic               nmi_n;
    logic               trap_state;
    logic               capture_address;
    logic [CAUSE_W-1:0] trap_cause;
    logic               double_fault;

    modport master (
        output m1_n, irq_n, irq_mask, io_violation, new_isr,
        output last_isr_untrap, virtual_enabled, fault_clr,
        input  nmi_n, trap_state, capture_address, trap_cause,
        input  double_fault
    );

    modport slave (
        input  m1_n, irq_n, irq_mask, io_violation, new_isr,
        input  last_isr_untrap, virtual_enabled, fault_clr,
        output nmi_n, trap_state, capture_address, trap_cause,
        output double_fault
    );
endinterface

// File: rtl/sync_edge.sv
// Multi-stage synchronizer with one-clock rise/fall pulses.
module sync_edge #(
    parameter int               WIDTH   = 1,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]             prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = q_o & ~prev_q;
    assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/trap_ctrl.sv
// Trap/NMI controller: preempts the guest into the handler and records why.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int NUM_IRQ     = 4,
    parameter int CAUSE_W     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      reset_n,
    trap_ctrl_if.slave bus
);

    logic               m1_sync, m1_rise, m1_fall;
    logic [NUM_IRQ-1:0] irq_sync, irq_unused_rise, irq_unused_fall;

    state_e             state_q, state_d;
    logic [CAUSE_W-1:0] cause_q, cause_d, enc;
    logic [NUM_IRQ-1:0] hold_q, hold_d, active;
    logic               viol_q, viol_d;
    logic               cap_q, cap_d;
    logic               nmi_q, nmi_d;
    logic               dfault_q, dfault_d;
    logic               pending, untrap_ok;

    sync_edge #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_m1_sync (
        .clk    (clk),
        .rst_n  (reset_n),
        .d_i    (bus.m1_n),
        .q_o    (m1_sync),
        .rise_o (m1_rise),
        .fall_o (m1_fall)
    );

    sync_edge #(.WIDTH(NUM_IRQ), .STAGES(SYNC_STAGES)) u_irq_sync (
        .clk    (clk),
        .rst_n  (reset_n),
        .d_i    (bus.irq_n),
        .q_o    (irq_sync),
        .rise_o (irq_unused_rise),
        .fall_o (irq_unused_fall)
    );

    assign active    = hold_q & bus.irq_mask;
    assign pending   = viol_q | (|active);
    assign untrap_ok = bus.last_isr_untrap & bus.virtual_enabled;

    // Violation outranks interrupts; among interrupts the lowest index wins.
    always_comb begin
        enc = CAUSE_W'(CAUSE_NONE);
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) enc = CAUSE_W'(CAUSE_IRQ_BASE + i);
        end
        if (viol_q) enc = CAUSE_W'(CAUSE_IOV);
    end

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        cap_d    = cap_q;
        viol_d   = viol_q;
        dfault_d = dfault_q;
        hold_d   = m1_rise ? ~irq_sync : hold_q;
        if (m1_fall) cap_d = 1'b0;
        if (bus.fault_clr) dfault_d = 1'b0;
        unique case (state_q)
            GUEST: begin
                if (m1_fall) begin
                    if (!bus.virtual_enabled) begin
                        state_d = TRAPPED;
                        cause_d = CAUSE_W'(CAUSE_NONE);
                    end else if (pending && bus.new_isr) begin
                        state_d = TRAPPED;
                        cause_d = enc;
                        cap_d   = 1'b1;
                        if (viol_q) viol_d = 1'b0;
                    end
                end
                // A violation on the entry edge is kept for after untrap.
                if (bus.io_violation) viol_d = 1'b1;
            end
            TRAPPED: begin
                if (m1_fall && untrap_ok) begin
                    state_d = GUEST;
                    cause_d = CAUSE_W'(CAUSE_NONE);
                end
                if (bus.io_violation) begin
                    viol_d   = 1'b0;
                    dfault_d = 1'b1;
                end
            end
        endcase
        nmi_d = !(state_q == GUEST && pending && m1_sync);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= GUEST;
            cause_q  <= '0;
            hold_q   <= '0;
            viol_q   <= 1'b0;
            cap_q    <= 1'b0;
            nmi_q    <= 1'b1;
            dfault_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            hold_q   <= hold_d;
            viol_q   <= viol_d;
            cap_q    <= cap_d;
            nmi_q    <= nmi_d;
            dfault_q <= dfault_d;
        end
    end

    assign bus.nmi_n           = nmi_q;
    assign bus.trap_state      = (state_q == TRAPPED);
    assign bus.capture_address = cap_q | ((state_q == TRAPPED) & untrap_ok);
    assign bus.trap_cause      = cause_q;
    assign bus.double_fault    = dfault_q;

endmodule
